rgb_segment_writer: RTL

- Upstream producer for the SRAM-backed VGA display path.
- Accepts a stream of 24-bit RGB pixels over a valid/ready handshake.
- Writes the pixels into SRAM in the segmented layout that the VGA fetch FSM reads:
  - red segment: pixel pairs
  - green segment: pixel pairs
  - blue-even segment: pixels 4g and 4g+2
  - blue-odd segment: pixels 4g+1 and 4g+3
- Replaces the hard-coded rectangle fill, so arbitrary images can be loaded (e.g. from UART or a pattern generator).

---
 rtl/rgb_segment_writer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/rgb_segment_writer.sv
// rgb_segment_writer: loads a frame of 24-bit RGB pixels into SRAM in the
// segmented layout read by the VGA fetch FSM.
// Pixels arrive four at a time (one group). Each group becomes six 16-bit words:
// two red pair words, two green pair words, one blue-even word and one blue-odd word.
// Optional feature macro: RGB_WRITER_CHECKSUM_EN adds a running 16-bit checksum output.
module rgb_segment_writer #(
    parameter logic [17:0] RED_START_ADDRESS       = 18'd0,
    parameter logic [17:0] GREEN_START_ADDRESS     = 18'd38400,
    parameter logic [17:0] BLUE_EVEN_START_ADDRESS = 18'd76800,
    parameter logic [17:0] BLUE_ODD_START_ADDRESS  = 18'd96000,
    parameter int          NUM_PIXELS              = 76800
) (
    input  logic        Clock_50,
    input  logic        Reset,
    input  logic        start,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [23:0] pix_rgb,
    output logic        busy,
    output logic        done,
    input  logic        SRAM_ready,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n
`ifdef RGB_WRITER_CHECKSUM_EN
    ,
    output logic [15:0] checksum
`endif
);

    typedef enum logic [3:0] {
        IDLE,
        COLLECT,
        W_R0,
        W_R1,
        W_G0,
        W_G1,
        W_BE,
        W_BO,
        FINISH
    } state_t;

    // Index of the final four-pixel group in the frame.
    localparam logic [14:0] LAST_G = 15'(NUM_PIXELS / 4 - 1);

    state_t      state_q;
    state_t      state_d;
    logic [14:0] g_q;
    logic [1:0]  k_q;
    logic [23:0] pix_buf [4];
    logic        we_reg;

    // Red and green segments hold two words per group; blue segments hold one.
    logic [17:0] pair_offset;
    logic [17:0] blue_offset;
    assign pair_offset = {2'b00, g_q, 1'b0};
    assign blue_offset = {3'b000, g_q};

    // State register.
    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; write states advance only when the SRAM accepts the word.
    always_comb begin
        // NOTE: default assignment first so every path drives state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = COLLECT;
            COLLECT: if (pix_valid && k_q == 2'd3) state_d = W_R0;
            W_R0:    if (SRAM_ready) state_d = W_R1;
            W_R1:    if (SRAM_ready) state_d = W_G0;
            W_G0:    if (SRAM_ready) state_d = W_G1;
            W_G1:    if (SRAM_ready) state_d = W_BE;
            W_BE:    if (SRAM_ready) state_d = W_BO;
            W_BO:    if (SRAM_ready) state_d = (g_q == LAST_G) ? FINISH : COLLECT;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: handshake ready, status flags and internal write enable.
    always_comb begin
        pix_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        we_reg    = 1'b1;
        case (state_q)
            COLLECT: begin
                pix_ready = 1'b1;
                busy      = 1'b1;
            end
            W_R0, W_R1, W_G0, W_G1, W_BE, W_BO: begin
                busy   = 1'b1;
                we_reg = 1'b0;
            end
            FINISH:  done = 1'b1;
            default: ;
        endcase
    end

    // A low SRAM_ready masks the write strobe in the same cycle.
    assign SRAM_we_n = we_reg | ~SRAM_ready;

    // Group and slot counters.
    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            g_q <= '0;
            k_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        g_q <= '0;
                        k_q <= '0;
                    end
                end
                COLLECT: begin
                    if (pix_valid) k_q <= k_q + 2'd1;
                end
                W_BO: begin
                    if (SRAM_ready && g_q != LAST_G) begin
                        g_q <= g_q + 15'd1;
                        k_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pixel buffer for the current group.
    always_ff @(posedge Clock_50) begin
        // NOTE: the buffer has no reset; every slot is rewritten before it is read.
        if (state_q == COLLECT && pix_valid) begin
            pix_buf[k_q] <= pix_rgb;
        end
    end

    // Address and data are registered on entry to each write state and held while stalled.
    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            SRAM_address    <= '0;
            SRAM_write_data <= '0;
        end else if (state_d != state_q) begin
            case (state_d)
                W_R0: begin
                    SRAM_address    <= RED_START_ADDRESS + pair_offset;
                    SRAM_write_data <= {pix_buf[0][23:16], pix_buf[1][23:16]};
                end
                W_R1: begin
                    SRAM_address    <= RED_START_ADDRESS + pair_offset + 18'd1;
                    SRAM_write_data <= {pix_buf[2][23:16], pix_buf[3][23:16]};
                end
                W_G0: begin
                    SRAM_address    <= GREEN_START_ADDRESS + pair_offset;
                    SRAM_write_data <= {pix_buf[0][15:8], pix_buf[1][15:8]};
                end
                W_G1: begin
                    SRAM_address    <= GREEN_START_ADDRESS + pair_offset + 18'd1;
                    SRAM_write_data <= {pix_buf[2][15:8], pix_buf[3][15:8]};
                end
                W_BE: begin
                    SRAM_address    <= BLUE_EVEN_START_ADDRESS + blue_offset;
                    SRAM_write_data <= {pix_buf[0][7:0], pix_buf[2][7:0]};
                end
                W_BO: begin
                    SRAM_address    <= BLUE_ODD_START_ADDRESS + blue_offset;
                    SRAM_write_data <= {pix_buf[1][7:0], pix_buf[3][7:0]};
                end
                IDLE:    SRAM_address <= '0;
                default: ;
            endcase
        end
    end

`ifdef RGB_WRITER_CHECKSUM_EN
    // Running sum of words actually written in the current frame.
    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            checksum <= '0;
        end else if (state_q == IDLE && start) begin
            checksum <= '0;
        end else if (!SRAM_we_n) begin
            checksum <= checksum + SRAM_write_data;
        end
    end
`endif

endmodule
